// File: rtl/gate_id_pkg.sv
// -----------------------------------------------------------------------------
// gate_id_pkg
// Shared definitions for the gate self-test identifier:
//   - gate codes GATE_UNKNOWN..GATE_XNOR reported on gate_code
//   - canonical truth tables TT_NOT_A..TT_XNOR (bit i = output for {a,b} = i)
//   - FSM state encoding used by gate_identifier
// Optional feature macro: GATE_ID_DOUBLE_CHECK_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package gate_id_pkg;

    localparam logic [2:0] GATE_UNKNOWN = 3'd0;
    localparam logic [2:0] GATE_NOT_A   = 3'd1;
    localparam logic [2:0] GATE_AND     = 3'd2;
    localparam logic [2:0] GATE_OR      = 3'd3;
    localparam logic [2:0] GATE_NAND    = 3'd4;
    localparam logic [2:0] GATE_NOR     = 3'd5;
    localparam logic [2:0] GATE_XOR     = 3'd6;
    localparam logic [2:0] GATE_XNOR    = 3'd7;

    localparam logic [3:0] TT_NOT_A = 4'b0011;
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1
`ifdef GATE_ID_DOUBLE_CHECK_EN
        ,
        ST_CHECK = 2'd2
`endif
    } gate_id_state_t;

endpackage

// File: rtl/gate_classifier.sv
// -----------------------------------------------------------------------------
// gate_classifier
// Purely combinational map from an observed 4-bit truth table to a gate code.
// Ports:
//   truth_table [3:0] in  : bit i = gate output for input vector {a,b} = i
//   gate_code   [2:0] out : GATE_* code, GATE_UNKNOWN for unrecognised tables
// -----------------------------------------------------------------------------
module gate_classifier (
    input  logic [3:0] truth_table,
    output logic [2:0] gate_code
);
    import gate_id_pkg::*;

    always_comb begin
        gate_code = GATE_UNKNOWN;
        case (truth_table)
            TT_NOT_A: gate_code = GATE_NOT_A;
            TT_AND:   gate_code = GATE_AND;
            TT_OR:    gate_code = GATE_OR;
            TT_NAND:  gate_code = GATE_NAND;
            TT_NOR:   gate_code = GATE_NOR;
            TT_XOR:   gate_code = GATE_XOR;
            TT_XNOR:  gate_code = GATE_XNOR;
            default:  gate_code = GATE_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/gate_identifier.sv
// -----------------------------------------------------------------------------
// gate_identifier
// Drives all four input vectors (00,01,10,11) onto a 2-input gate under test,
// samples its output after each vector has settled, and classifies the
// resulting truth table.
// Parameters:
//   SETTLE_CYCLES : extra hold cycles per vector before sampling (0..15)
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a run (accepted in IDLE only)
//   a_out, b_out      : stimulus to the gate's a / b inputs
//   y_in              : gate output under observation
//   busy              : run in progress
//   done              : one-cycle pulse when results update
//   truth_table [3:0] : bit i = sampled y_in for vector {a,b} = i
//   gate_code   [2:0] : classification (GATE_* codes)
//   unstable          : pass 1 and pass 2 disagreed
// Macro GATE_ID_DOUBLE_CHECK_EN: repeat the sweep in a CHECK pass and flag any
// disagreement; without it, one pass and unstable is tied low.
// -----------------------------------------------------------------------------
module gate_identifier #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_code,
    output logic       unstable
);
    import gate_id_pkg::*;

    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

    gate_id_state_t   state;
    logic [1:0]       vec_idx;
    logic [1:0]       vec_next;
    logic [CNT_W-1:0] settle_cnt;
    logic [3:0]       tt_work;
    logic [3:0]       tt_captured;
    logic [3:0]       classify_in;
    logic [2:0]       classified;
    logic             vec_last_cycle;

    // tt_captured is the table including the sample taken on this edge, so
    // the final vector's sample can be registered and classified at once.
    always_comb begin
        tt_captured          = tt_work;
        tt_captured[vec_idx] = y_in;
        vec_last_cycle       = (settle_cnt == SETTLE_LAST);
        vec_next             = vec_idx + 2'd1;
    end

`ifdef GATE_ID_DOUBLE_CHECK_EN
    logic [3:0] tt_pass1;
    logic       unstable_q;
    assign classify_in = tt_pass1;
    assign unstable    = unstable_q;
`else
    assign classify_in = tt_captured;
    assign unstable    = 1'b0;
`endif

    gate_classifier u_classifier (
        .truth_table (classify_in),
        .gate_code   (classified)
    );

    // Main sequencer: holds each vector for SETTLE_CYCLES+1 cycles, samples
    // on the last edge, and registers all results together when the sweep
    // finishes. done defaults low so it only lives for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            vec_idx     <= 2'd0;
            settle_cnt  <= '0;
            tt_work     <= 4'd0;
            a_out       <= 1'b0;
            b_out       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 4'd0;
            gate_code   <= GATE_UNKNOWN;
`ifdef GATE_ID_DOUBLE_CHECK_EN
            tt_pass1    <= 4'd0;
            unstable_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        busy       <= 1'b1;
                        vec_idx    <= 2'd0;
                        settle_cnt <= '0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                    end
                end

                ST_DRIVE: begin
                    if (!vec_last_cycle) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else begin
                        tt_work    <= tt_captured;
                        settle_cnt <= '0;
                        if (vec_idx == 2'd3) begin
                            vec_idx <= 2'd0;
                            a_out   <= 1'b0;
                            b_out   <= 1'b0;
`ifdef GATE_ID_DOUBLE_CHECK_EN
                            state    <= ST_CHECK;
                            tt_pass1 <= tt_captured;
`else
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            truth_table <= tt_captured;
                            gate_code   <= classified;
`endif
                        end else begin
                            vec_idx        <= vec_next;
                            {a_out, b_out} <= vec_next;
                        end
                    end
                end

`ifdef GATE_ID_DOUBLE_CHECK_EN
                // Second sweep: the stored pass-1 table is what gets reported,
                // any disagreement from pass 2 voids the classification.
                ST_CHECK: begin
                    if (!vec_last_cycle) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else begin
                        tt_work    <= tt_captured;
                        settle_cnt <= '0;
                        if (vec_idx == 2'd3) begin
                            state       <= ST_IDLE;
                            vec_idx     <= 2'd0;
                            a_out       <= 1'b0;
                            b_out       <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            truth_table <= tt_pass1;
                            if (tt_captured != tt_pass1) begin
                                unstable_q <= 1'b1;
                                gate_code  <= GATE_UNKNOWN;
                            end else begin
                                unstable_q <= 1'b0;
                                gate_code  <= classified;
                            end
                        end else begin
                            vec_idx        <= vec_next;
                            {a_out, b_out} <= vec_next;
                        end
                    end
                end
`endif

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_identifier.sv
// -----------------------------------------------------------------------------
// tb_gate_identifier
// Self-checking bench for gate_identifier with SETTLE_CYCLES = 2. The gate
// under test is modelled as a 4-bit lookup driven from a_out/b_out. Expected
// gate codes come from a reference that evaluates each gate's boolean
// function over all inputs. Aware of GATE_ID_DOUBLE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_gate_identifier;

    localparam int S       = 2;
    localparam int VEC_CYC = S + 1;
`ifdef GATE_ID_DOUBLE_CHECK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int L = 4 * VEC_CYC * PASSES;

    logic       clk;
    logic       rst;
    logic       start;
    logic       a_out;
    logic       b_out;
    logic       y_in;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_code;
    logic       unstable;

    logic [3:0] cur_func;
    int         n_checks;
    int         n_fail;

    gate_identifier #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_out       (a_out),
        .b_out       (b_out),
        .y_in        (y_in),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table),
        .gate_code   (gate_code),
        .unstable    (unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test: lookup of the current function table by {a,b}.
    always_comb y_in = cur_func[{a_out, b_out}];

    // Truth table of gate number g (1..7), built by evaluating the gate.
    function automatic logic [3:0] gate_table(int g);
        logic [3:0] t;
        logic       a;
        logic       b;
        t = 4'd0;
        for (int v = 0; v < 4; v++) begin
            a = v[1];
            b = v[0];
            case (g)
                1: t[v] = ~a;
                2: t[v] = a & b;
                3: t[v] = a | b;
                4: t[v] = ~(a & b);
                5: t[v] = ~(a | b);
                6: t[v] = a ^ b;
                7: t[v] = ~(a ^ b);
                default: t[v] = 1'b0;
            endcase
        end
        return t;
    endfunction

    function automatic logic [2:0] ref_code(logic [3:0] tt);
        for (int g = 1; g <= 7; g++)
            if (gate_table(g) == tt) return 3'(g);
        return 3'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " done"}, 32'(done), 32'd0);
        check({name, " ab"}, 32'({a_out, b_out}), 32'd0);
        check({name, " tt"}, 32'(truth_table), 32'd0);
        check({name, " code"}, 32'(gate_code), 32'd0);
        check({name, " unstable"}, 32'(unstable), 32'd0);
    endtask

    // One complete run. Must be called while not on a clock edge; start is
    // raised immediately and sampled at the next rising edge. Returns at #1
    // into the done cycle so a caller may chain the next run back-to-back.
    task automatic do_run(input logic [3:0] f1, input logic [3:0] f2, input logic [2:0] code1,
                          input bit hold_start, input string name);
        logic       exp_unst;
        logic [2:0] exp_code;
        logic [1:0] vi;
        int         bad_busy;
        int         bad_vec;
        exp_unst = (PASSES == 2) && (f1 != f2);
        exp_code = exp_unst ? 3'd0 : code1;
        cur_func = f1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        bad_busy = 0;
        bad_vec  = 0;
        for (int i = 0; i < L; i++) begin
            if (i == 4 * VEC_CYC) cur_func = f2;
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            vi = 2'((i % (4 * VEC_CYC)) / VEC_CYC);
            if ({a_out, b_out} !== vi) bad_vec++;
            @(posedge clk);
            #1;
        end
        check({name, " busy window"}, 32'(bad_busy), 32'd0);
        check({name, " vector order"}, 32'(bad_vec), 32'd0);
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " busy end"}, 32'(busy), 32'd0);
        check({name, " ab idle"}, 32'({a_out, b_out}), 32'd0);
        check({name, " tt"}, 32'(truth_table), 32'(f1));
        check({name, " code"}, 32'(gate_code), 32'(exp_code));
        check({name, " unstable"}, 32'(unstable), 32'(exp_unst));
    endtask

    typedef struct {
        logic [3:0] func;
        logic [2:0] exp_code;
        string      name;
    } vec_t;

    vec_t       vecs[9];
    logic [3:0] rnd_tt;
    int         done_seen;

    initial begin
        vecs[0] = '{4'b0011, 3'd1, "not_a"};
        vecs[1] = '{4'b1000, 3'd2, "and"};
        vecs[2] = '{4'b1110, 3'd3, "or"};
        vecs[3] = '{4'b0111, 3'd4, "nand"};
        vecs[4] = '{4'b0001, 3'd5, "nor"};
        vecs[5] = '{4'b0110, 3'd6, "xor"};
        vecs[6] = '{4'b1001, 3'd7, "xnor"};
        vecs[7] = '{4'b1111, 3'd0, "const1"};
        vecs[8] = '{4'b0000, 3'd0, "const0"};

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        cur_func = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single AND run.
        do_run(4'b1000, 4'b1000, 3'd2, 1'b0, "and_single");

        // Back-to-back sweep: each start issued inside the previous done cycle.
        for (int k = 0; k < 9; k++)
            do_run(vecs[k].func, vecs[k].func, vecs[k].exp_code, 1'b0, vecs[k].name);

        // Randomised tables against the reference model.
        for (int k = 0; k < 8; k++) begin
            rnd_tt = 4'($urandom_range(0, 15));
            do_run(rnd_tt, rnd_tt, ref_code(rnd_tt), 1'b0, "random");
        end

        // Reset during vector 10 aborts with no done.
        @(negedge clk);
        cur_func = 4'b1110;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2 * VEC_CYC) begin
            @(posedge clk);
            #1;
        end
        check("abort at vector 10", 32'({a_out, b_out}), 32'b10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        done_seen = 0;
        repeat (L + 2) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);
        do_run(4'b1110, 4'b1110, 3'd3, 1'b0, "after_abort");

        // start held high: one run per acceptance, chained without gap.
        @(negedge clk);
        do_run(4'b0111, 4'b0111, 3'd4, 1'b1, "held1");
        do_run(4'b0001, 4'b0001, 3'd5, 1'b1, "held2");
        start = 1'b0;
        @(posedge clk);
        #1;
        check("held release idle", 32'(busy), 32'd0);
        check("held release done", 32'(done), 32'd0);

`ifdef GATE_ID_DOUBLE_CHECK_EN
        // Disagreeing passes flag unstable; a stable run clears it again.
        @(negedge clk);
        do_run(4'b0110, 4'b1001, 3'd6, 1'b0, "unstable_xor");
        do_run(4'b0110, 4'b0110, 3'd6, 1'b0, "stable_xor");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_identifier.md
# gate_identifier

Sequential stimulus-and-analysis engine for a 2-input primitive gate under test.
- On `start`, drives all four input combinations onto `a_out`/`b_out` and samples the gate's response on `y_in` for each one.
- Assembles the 4-bit truth table and classifies it as one of the seven gate functions the codebase provides, or as UNKNOWN.
- Acts as the receiving end of the gate-library interface: the gates turn inputs into outputs, this block turns observed outputs back into a gate identity. It sits in the gate self-test harness.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling. Legal range 0..15.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin identification; accepted only when the FSM is in IDLE.
- `a_out` output 1: drive to the gate's `a` input.
- `b_out` output 1: drive to the gate's `b` input.
- `y_in` input 1: gate output under observation.
- `busy` output 1: high while a run is in progress.
- `done` output 1: one-cycle pulse when results update.
- `truth_table` output 4: bit i = sampled `y_in` for vector i, where i = {a,b}.
- `gate_code` output 3: classification result.
- `unstable` output 1: the two passes disagreed (see Configuration).

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - DRIVE: applies the current vector and counts settle cycles.
  - CHECK: second pass; exists only when the macro is defined.
- Vector order is 00, 01, 10, 11, with `a_out` = MSB of the 2-bit vector index.
- Each vector is held for SETTLE_CYCLES+1 cycles.
- `y_in` is sampled at the rising edge that ends the vector's final cycle.
- After vector 11 is sampled:
  - The FSM returns to IDLE.
  - `truth_table`, `gate_code` and `unstable` register simultaneously.
  - `done` is 1 for exactly that first IDLE cycle.
- Classification of `truth_table` to `gate_code`:
  - 0011 → 1 NOT_A
  - 1000 → 2 AND
  - 1110 → 3 OR
  - 0111 → 4 NAND
  - 0001 → 5 NOR
  - 0110 → 6 XOR
  - 1001 → 7 XNOR
  - any other table → 0 UNKNOWN
- Results hold until the next run completes. They do not clear at the start of a run.
- `start` while busy is ignored.
- `start` in the `done` cycle is accepted: the next run begins on the following cycle, and `done` still pulses.
- `a_out`/`b_out` are 0 in IDLE.
- Settle counter width is max(1, $clog2(SETTLE_CYCLES+1)).
- The counter and vector index wrap only through the reset to 0 at the start of each vector or pass; neither ever overflows.

## Timing
- Reset values: `busy`, `done`, `a_out`, `b_out`, `unstable` = 0; `truth_table` = 0000; `gate_code` = 0. The FSM enters IDLE.
- `rst` mid-run aborts immediately on that edge. All outputs return to reset values and no `done` is generated.
- `start` sampled high at edge N gives `busy`=1 and vector 00 on the outputs from cycle N+1.
- Run length is L = 4·(SETTLE_CYCLES+1) busy cycles, doubled when the macro is defined.
- `done` asserts in cycle N+1+L; `busy` is 0 in that cycle.
- `y_in` is treated as synchronous. Combinational gate paths settle within SETTLE_CYCLES+1 cycles by construction.

## Configuration
- `GATE_ID_DOUBLE_CHECK_EN` defined:
  - After pass 1, the FSM enters CHECK and repeats all four vectors.
  - Pass-2 samples are compared to pass 1. Any mismatch sets `unstable`=1 and forces `gate_code`=0; `truth_table` reports pass 1.
  - Run length becomes 8·(SETTLE_CYCLES+1).
- Not defined: single pass, CHECK state absent, and `unstable` is tied to 0.

## Structure
- Package `gate_id_pkg` holds:
  - gate code localparams GATE_UNKNOWN..GATE_XNOR;
  - truth-table constants TT_NOT_A..TT_XNOR;
  - the FSM state encoding.
- Sub-module `gate_classifier`: purely combinational mapping of 4-bit truth table to 3-bit code. It is reused by software-model checks.

## Test plan
All scenarios use SETTLE_CYCLES=2.
- `y_in` = `a_out`&`b_out`, pulse `start` → `busy` high 12 cycles; `done` pulse 13 cycles after the start edge; `truth_table`=1000, `gate_code`=2.
- Sweep `y_in` across the seven gate functions in back-to-back runs, each reissuing `start` in the `done` cycle → codes 1..7 in order; no idle gap between runs.
- `y_in` tied to 1 → `truth_table`=1111, `gate_code`=0.
- Assert `rst` during vector 10 → next cycle all outputs 0, no `done`; a following run completes normally.
- `start` held high for a whole run → exactly one run per IDLE acceptance, and `done` is followed immediately by a new run.
- Macro defined, `y_in` = XOR in pass 1 and XNOR in pass 2 → after 24 cycles, `unstable`=1, `gate_code`=0, `truth_table`=0110.
